mux7_in: RTL and testbench
==========================

MUX7_IN -- requirements
Module: mux7_in

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every data input and output.
REQ-002 SHALL have port clk  input  1  system clock; rising-edge active; the block's only clock.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port Order  input  3  select code; 0..6 pick DataIn0..DataIn6; 7 illegal.
REQ-005 SHALL have port En  input  1  capture enable; sample and register the selected input this cycle.
REQ-006 SHALL have ports DataIn0..DataIn6  input  WIDTH each  candidate data words.
REQ-007 SHALL have port DataOut  output  WIDTH  registered selected word.
REQ-008 SHALL have port DataOutC  output  WIDTH  combinational selected word, zero latency.
REQ-009 SHALL have port Valid  output  1  DataOut updated on the previous edge.
REQ-010 SHALL have port SelErr  output  1  previous capture used illegal Order=7.

Function
REQ-011 DataOutC SHALL equal DataIn[Order] combinationally for Order 0..6, and all-zero for Order=7.
REQ-012 DataOutC SHALL change in the same delta as any change on Order or the selected DataIn; no latch inference.
REQ-013 On a rising clk edge with En=1, DataOut SHALL load the DataOutC value; latency one cycle.
REQ-014 On a rising clk edge with En=0, DataOut SHALL hold its previous value.
REQ-015 Valid SHALL be registered En: 1 for exactly the cycle after each En=1 edge, else 0.
REQ-016 SHALL set SelErr to 1 on an edge with En=1 and Order=7; DataOut SHALL load zero on that edge.
REQ-017 SHALL clear SelErr to 0 on an edge with En=1 and Order in 0..6.
REQ-018 On an edge with En=0, SelErr SHALL hold its previous value.
REQ-019 Back-to-back En=1 cycles SHALL each capture independently; throughput one word per cycle.
REQ-020 Changes on non-selected DataIn ports SHALL NOT affect DataOutC or DataOut.
REQ-021 Order or DataIn changes between edges SHALL affect DataOut only through the value present at the next En=1 edge.

Reset
REQ-022 While rst_n=0, DataOut SHALL be 0, Valid 0, SelErr 0, immediately and independent of clk.
REQ-023 Reset asserted mid-operation SHALL discard any pending capture; no capture SHALL occur on an edge while rst_n=0.
REQ-024 After rst_n deasserts, the first rising edge with En=1 SHALL capture normally.
REQ-025 DataOutC SHALL be unaffected by reset; it is purely combinational.

Verification
REQ-026 DataInN=N for N=0..6, Order=0, En=0 -> DataOutC=0; DataOut holds reset value 0; Valid=0.
REQ-027 Same data; sweep Order 0..6 with En=1 each cycle -> DataOutC=Order immediately; DataOut=Order one cycle later; Valid=1; SelErr=0.
REQ-028 Order=7, En=1 -> DataOutC=0; next cycle DataOut=0, SelErr=1. Then Order=3, En=1 -> DataOut=3, SelErr=0.
REQ-029 Capture Order=5 (DataOut=5), then En=0 with Order=2 for 3 cycles -> DataOut stays 5, Valid=0, DataOutC=2.
REQ-030 DataOut=6, SelErr=1 state, pulse rst_n low between edges -> DataOut, Valid, SelErr drop to 0 at once, without a clk edge.
REQ-031 Order=4, change DataIn0 to 32'hFFFFFFFF -> DataOutC stays 4; changing DataIn4 to 32'hA5A5A5A5 -> DataOutC=32'hA5A5A5A5.

Source files
------------

// File: rtl/mux7_in.sv
// -----------------------------------------------------------------------------
// mux7_in
//
// Seven-way word selector with a combinational output and a registered
// capture path.
//
// The combinational path (DataOutC) always shows the word picked by Order.
// Code 7 is not a legal select, so that code yields all-zero. This path does
// not depend on clk or reset.
//
// The registered path (DataOut) loads the combinational word on every rising
// edge where En=1, and holds its value otherwise.
//   - Valid flags the cycle just after each capture.
//   - SelErr records whether the most recent capture used the illegal code.
//
// Ports
//   clk               in   1      rising-edge clock
//   rst_n             in   1      asynchronous active-low reset
//   Order             in   3      select code, 0..6 legal, 7 illegal
//   En                in   1      capture enable
//   DataIn0..DataIn6  in   WIDTH  candidate words
//   DataOut           out  WIDTH  registered selected word
//   DataOutC          out  WIDTH  combinational selected word
//   Valid             out  1      DataOut was loaded on the previous edge
//   SelErr            out  1      previous capture used Order=7
// -----------------------------------------------------------------------------
module mux7_in #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       Order,
   input  logic             En,
   input  logic [WIDTH-1:0] DataIn0,
   input  logic [WIDTH-1:0] DataIn1,
   input  logic [WIDTH-1:0] DataIn2,
   input  logic [WIDTH-1:0] DataIn3,
   input  logic [WIDTH-1:0] DataIn4,
   input  logic [WIDTH-1:0] DataIn5,
   input  logic [WIDTH-1:0] DataIn6,
   output logic [WIDTH-1:0] DataOut,
   output logic [WIDTH-1:0] DataOutC,
   output logic             Valid,
   output logic             SelErr
);

   logic [WIDTH-1:0] w_sel;
   logic             w_illegal;

   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_selerr;

   // Selection path. The default assignment makes code 7 produce zero and
   // also guarantees that no latch is inferred.
   always_comb begin
      w_sel = '0;
      case (Order)
         3'd0:    w_sel = DataIn0;
         3'd1:    w_sel = DataIn1;
         3'd2:    w_sel = DataIn2;
         3'd3:    w_sel = DataIn3;
         3'd4:    w_sel = DataIn4;
         3'd5:    w_sel = DataIn5;
         3'd6:    w_sel = DataIn6;
         default: w_sel = '0;
      endcase
   end

   assign w_illegal = (Order == 3'd7);

   // Capture stage. Because the reset is asynchronous, any capture that is
   // pending when reset is asserted is discarded, and no edge seen while
   // rst_n=0 can load anything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_selerr <= 1'b0;
      end else begin
         r_valid <= En;
         if (En) begin
            // w_sel is already zero for the illegal code.
            r_data   <= w_sel;
            r_selerr <= w_illegal;
         end
      end
   end

   assign DataOutC = w_sel;
   assign DataOut  = r_data;
   assign Valid    = r_valid;
   assign SelErr   = r_selerr;

endmodule

// File: tb/tb_mux7_in.sv
module tb_mux7_in;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic [2:0]       Order;
   logic             En;
   logic [WIDTH-1:0] din [7];
   logic [WIDTH-1:0] DataOut;
   logic [WIDTH-1:0] DataOutC;
   logic             Valid;
   logic             SelErr;

   // Reference model state.
   logic [WIDTH-1:0] m_out;
   logic             m_vld;
   logic             m_err;

   int n_chk;
   int n_fail;

   mux7_in #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .Order    (Order),
      .En       (En),
      .DataIn0  (din[0]),
      .DataIn1  (din[1]),
      .DataIn2  (din[2]),
      .DataIn3  (din[3]),
      .DataIn4  (din[4]),
      .DataIn5  (din[5]),
      .DataIn6  (din[6]),
      .DataOut  (DataOut),
      .DataOutC (DataOutC),
      .Valid    (Valid),
      .SelErr   (SelErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                      input logic [WIDTH-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: the selected word is the addressed array element, or zero when
   // the code is out of the 0..6 range.
   function automatic logic [WIDTH-1:0] ref_sel(input logic [2:0] o);
      if (int'(o) < 7) return din[o];
      return '0;
   endfunction

   task automatic check_regs(input string tag);
      chk({tag, ".DataOut"}, DataOut, m_out);
      chk({tag, ".Valid"}, WIDTH'(Valid), WIDTH'(m_vld));
      chk({tag, ".SelErr"}, WIDTH'(SelErr), WIDTH'(m_err));
   endtask

   // Drive one cycle: set inputs on the falling edge, check the combinational
   // word, then let the rising edge capture and check the registered outputs.
   task automatic step(input logic en_i, input logic [2:0] ord_i, input string tag);
      @(negedge clk);
      En    = en_i;
      Order = ord_i;
      #1;
      chk({tag, ".DataOutC"}, DataOutC, ref_sel(ord_i));
      @(posedge clk);
      if (en_i) begin
         m_out = ref_sel(ord_i);
         m_err = (ord_i == 3'd7);
      end
      m_vld = en_i;
      #1;
      check_regs(tag);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      En     = 1'b0;
      Order  = 3'd0;
      for (int i = 0; i < 7; i++) din[i] = WIDTH'(i);
      m_out = '0;
      m_vld = 1'b0;
      m_err = 1'b0;

      // Reset state is visible before any clock edge.
      #2;
      check_regs("rst_async");
      chk("rst.DataOutC", DataOutC, 32'd0);

      // Edges seen while held in reset must not capture anything.
      En = 1'b1;
      Order = 3'd3;
      repeat (2) @(posedge clk);
      #1;
      check_regs("rst_hold");
      @(negedge clk);
      En = 1'b0;
      rst_n = 1'b1;

      // Idle with En low: nothing is loaded.
      step(1'b0, 3'd0, "idle");

      // Sweep every legal code back to back.
      for (int o = 0; o < 7; o++) step(1'b1, 3'(o), "sweep");

      // Illegal code, then recovery with a legal capture.
      step(1'b1, 3'd7, "ill");
      chk("ill.SelErr_set", WIDTH'(SelErr), 32'd1);
      step(1'b1, 3'd3, "ill_clr");
      chk("ill_clr.DataOut", DataOut, 32'd3);

      // Hold: capture 5, then three idle cycles on code 2.
      step(1'b1, 3'd5, "hold_cap");
      for (int k = 0; k < 3; k++) step(1'b0, 3'd2, "hold");
      chk("hold.DataOut5", DataOut, 32'd5);

      // SelErr persists across idle cycles, then reset drops it at once.
      step(1'b1, 3'd7, "err_set");
      step(1'b0, 3'd1, "err_hold");
      #2;
      rst_n = 1'b0;
      #1;
      m_out = '0; m_vld = 1'b0; m_err = 1'b0;
      check_regs("rst_mid_err");
      @(negedge clk);
      rst_n = 1'b1;

      // Asynchronous reset asserted between edges, with a capture of 6 pending.
      step(1'b1, 3'd6, "pre_rst");
      chk("pre_rst.DataOut6", DataOut, 32'd6);
      #2;
      rst_n = 1'b0;
      #1;
      m_out = '0; m_vld = 1'b0; m_err = 1'b0;
      check_regs("rst_mid");
      chk("rst_mid.DataOutC", DataOutC, ref_sel(Order));
      @(posedge clk);
      #1;
      check_regs("rst_mid_edge");
      @(negedge clk);
      rst_n = 1'b1;

      // The first capture after reset behaves normally.
      step(1'b1, 3'd3, "post_rst");

      // Changes on unselected inputs are ignored; the selected one is seen.
      step(1'b0, 3'd4, "sel4");
      din[0] = 32'hFFFF_FFFF;
      #1;
      chk("nonsel.DataOutC", DataOutC, 32'd4);
      din[4] = 32'hA5A5_A5A5;
      #1;
      chk("sel.DataOutC", DataOutC, 32'hA5A5_A5A5);
      step(1'b1, 3'd4, "sel_cap");

      // Randomized traffic; data words also change between edges.
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 7; i++) din[i] = $urandom;
         step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
